// File: rtl/axi_cache_pkg.sv
// Shared types and constants for the cache's AXI master-port datapath blocks.
`timescale 1ns/1ps
package axi_cache_pkg;

   // AXI burst length field width (ARLEN/AWLEN are beats-1)
   localparam int AXI_LEN_W  = 8;
   // Default data/id widths used by the cache's AXI port
   localparam int AXI_DATA_W = 64;
   localparam int AXI_ID_W   = 4;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   // One R-channel beat at the default port widths
   typedef struct packed {
      logic [AXI_DATA_W-1:0] data;
      logic [AXI_ID_W-1:0]   id;
      axi_resp_e             resp;
      logic                  last;
   } r_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with full/empty flags and a combinational head read.
`timescale 1ns/1ps
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   // Storage write; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

   // Pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/axi_r_return.sv
// AXI read-return path: AR pass-through with ARLEN tracking, R skid buffer,
// and sticky burst-consistency error flags.
`timescale 1ns/1ps
module axi_r_return
   import axi_cache_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = AXI_DATA_W,
   parameter int AXI_ID_WIDTH   = AXI_ID_W,
   parameter int LEN_DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [AXI_ADDR_WIDTH-1:0] dr_araddr,
   input  logic [AXI_ID_WIDTH-1:0]   dr_arid,
   input  logic [AXI_LEN_W-1:0]      dr_arlen,
   input  logic                      dr_arvalid,
   output logic                      dr_arready,
   output logic [AXI_ADDR_WIDTH-1:0] mr_araddr,
   output logic [AXI_ID_WIDTH-1:0]   mr_arid,
   output logic [AXI_LEN_W-1:0]      mr_arlen,
   output logic                      mr_arvalid,
   input  logic                      mr_arready,
   input  logic [AXI_DATA_WIDTH-1:0] mr_rdata,
   input  logic [AXI_ID_WIDTH-1:0]   mr_rid,
   input  logic [1:0]                mr_rresp,
   input  logic                      mr_rlast,
   input  logic                      mr_rvalid,
   output logic                      mr_rready,
   output logic [AXI_DATA_WIDTH-1:0] dr_rdata,
   output logic [AXI_ID_WIDTH-1:0]   dr_rid,
   output logic [1:0]                dr_rresp,
   output logic                      dr_rlast,
   output logic                      dr_rvalid,
   input  logic                      dr_rready,
   input  logic                      err_clr,
   output logic                      err_rlast,
   output logic                      err_unexp
);

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [AXI_ID_WIDTH-1:0]   id;
      axi_resp_e                 resp;
      logic                      last;
   } beat_t;

   logic                 w_len_full;
   logic                 w_len_empty;
   logic                 w_len_push;
   logic                 w_len_pop;
   logic [AXI_LEN_W-1:0] w_len_head;
   logic [AXI_LEN_W-1:0] r_beat_cnt;

   beat_t r_main;
   beat_t r_skid;
   beat_t w_in_beat;
   logic  r_main_valid;
   logic  r_skid_valid;
   logic  w_mr_hs;
   logic  w_dr_hs;
   logic  w_exp_last;
   logic  w_set_rlast;
   logic  w_set_unexp;
   logic  r_err_rlast;
   logic  r_err_unexp;

   // AR channel: payload passes straight through, valid/ready gated by FIFO space
   assign mr_araddr  = dr_araddr;
   assign mr_arid    = dr_arid;
   assign mr_arlen   = dr_arlen;
   assign mr_arvalid = dr_arvalid & ~w_len_full;
   assign dr_arready = mr_arready & ~w_len_full;
   assign w_len_push = mr_arvalid & mr_arready;

   sync_fifo #(
      .WIDTH (AXI_LEN_W),
      .DEPTH (LEN_DEPTH)
   ) u_len_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_len_push),
      .i_wdata (dr_arlen),
      .i_pop   (w_len_pop),
      .o_rdata (w_len_head),
      .o_full  (w_len_full),
      .o_empty (w_len_empty)
   );

   // R channel handshakes; ready is a pure register (skid slot free)
   assign mr_rready = ~r_skid_valid;
   assign w_mr_hs   = mr_rvalid & ~r_skid_valid;
   assign w_dr_hs   = r_main_valid & dr_rready;
   assign w_in_beat = '{data: mr_rdata, id: mr_rid, resp: axi_resp_e'(mr_rresp), last: mr_rlast};

   assign dr_rdata  = r_main.data;
   assign dr_rid    = r_main.id;
   assign dr_rresp  = r_main.resp;
   assign dr_rlast  = r_main.last;
   assign dr_rvalid = r_main_valid;

   // Skid buffer: main register feeds the driver, skid catches a beat when main is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main       <= '0;
         r_main_valid <= 1'b0;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_dr_hs) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_mr_hs) begin
            r_main       <= w_in_beat;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_mr_hs) begin
         r_skid       <= w_in_beat;
         r_skid_valid <= 1'b1;
      end
   end

   // Burst checker: compare beat position against the oldest outstanding ARLEN
   assign w_exp_last  = (r_beat_cnt == w_len_head);
   assign w_set_unexp = w_mr_hs & w_len_empty;
   assign w_set_rlast = w_mr_hs & ~w_len_empty & (mr_rlast != w_exp_last);
   assign w_len_pop   = w_mr_hs & ~w_len_empty & w_exp_last;

   // Beat counter within the current burst; held while no burst is outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt <= '0;
      end else if (w_mr_hs && !w_len_empty) begin
         r_beat_cnt <= w_exp_last ? '0 : r_beat_cnt + 1'b1;
      end
   end

   // Sticky error flags; clear wins over a same-cycle set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_rlast <= 1'b0;
         r_err_unexp <= 1'b0;
      end else if (err_clr) begin
         r_err_rlast <= 1'b0;
         r_err_unexp <= 1'b0;
      end else begin
         if (w_set_rlast) r_err_rlast <= 1'b1;
         if (w_set_unexp) r_err_unexp <= 1'b1;
      end
   end

   assign err_rlast = r_err_rlast;
   assign err_unexp = r_err_unexp;

endmodule

// File: tb/tb_axi_r_return.sv
// Randomized bench for axi_r_return with a transaction-level reference model.
`timescale 1ns/1ps
module tb_axi_r_return;
   import axi_cache_pkg::*;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;
   localparam int LD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] dr_araddr = '0;
   logic [IW-1:0] dr_arid = '0;
   logic [7:0]    dr_arlen = '0;
   logic          dr_arvalid = 1'b0;
   logic          dr_arready;
   logic [AW-1:0] mr_araddr;
   logic [IW-1:0] mr_arid;
   logic [7:0]    mr_arlen;
   logic          mr_arvalid;
   logic          mr_arready = 1'b1;
   logic [DW-1:0] mr_rdata = '0;
   logic [IW-1:0] mr_rid = '0;
   logic [1:0]    mr_rresp = '0;
   logic          mr_rlast = 1'b0;
   logic          mr_rvalid = 1'b0;
   logic          mr_rready;
   logic [DW-1:0] dr_rdata;
   logic [IW-1:0] dr_rid;
   logic [1:0]    dr_rresp;
   logic          dr_rlast;
   logic          dr_rvalid;
   logic          dr_rready = 1'b1;
   logic          err_clr = 1'b0;
   logic          err_rlast;
   logic          err_unexp;

   axi_r_return #(
      .AXI_ADDR_WIDTH (AW),
      .AXI_DATA_WIDTH (DW),
      .AXI_ID_WIDTH   (IW),
      .LEN_DEPTH      (LD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dr_araddr  (dr_araddr),
      .dr_arid    (dr_arid),
      .dr_arlen   (dr_arlen),
      .dr_arvalid (dr_arvalid),
      .dr_arready (dr_arready),
      .mr_araddr  (mr_araddr),
      .mr_arid    (mr_arid),
      .mr_arlen   (mr_arlen),
      .mr_arvalid (mr_arvalid),
      .mr_arready (mr_arready),
      .mr_rdata   (mr_rdata),
      .mr_rid     (mr_rid),
      .mr_rresp   (mr_rresp),
      .mr_rlast   (mr_rlast),
      .mr_rvalid  (mr_rvalid),
      .mr_rready  (mr_rready),
      .dr_rdata   (dr_rdata),
      .dr_rid     (dr_rid),
      .dr_rresp   (dr_rresp),
      .dr_rlast   (dr_rlast),
      .dr_rvalid  (dr_rvalid),
      .dr_rready  (dr_rready),
      .err_clr    (err_clr),
      .err_rlast  (err_rlast),
      .err_unexp  (err_unexp)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: beats accepted but not yet delivered, outstanding burst lengths
   r_beat_t    m_q[$];
   logic [7:0] m_lens[$];
   int         m_idx = 0;
   bit         m_err_r = 0;
   bit         m_err_u = 0;

   // Evaluate pre-edge state at the falling edge, then advance the model across the next rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_lens.delete();
         m_idx   = 0;
         m_err_r = 0;
         m_err_u = 0;
      end else begin
         bit      ar_ok, mr_hs, dr_hs, set_r, set_u, exp_last;
         r_beat_t nb;
         ar_ok = dr_arvalid && mr_arready && (m_lens.size() < LD);
         mr_hs = mr_rvalid && (m_q.size() < 2);
         dr_hs = dr_rready && (m_q.size() > 0);
         set_r = 0;
         set_u = 0;
         check_eq("dr_rvalid", dr_rvalid, m_q.size() > 0);
         check_eq("mr_rready", mr_rready, m_q.size() < 2);
         if (m_q.size() > 0)
            check_eq("dr_beat", {dr_rdata, dr_rid, dr_rresp, dr_rlast}, m_q[0]);
         check_eq("err_rlast", err_rlast, m_err_r);
         check_eq("err_unexp", err_unexp, m_err_u);
         check_eq("mr_arvalid", mr_arvalid, dr_arvalid && (m_lens.size() < LD));
         check_eq("dr_arready", dr_arready, mr_arready && (m_lens.size() < LD));
         check_eq("ar_payload", {mr_araddr, mr_arid, mr_arlen}, {dr_araddr, dr_arid, dr_arlen});
         if (dr_hs) begin
            $display("beat data=%h id=%h resp=%0d last=%0d", m_q[0].data, m_q[0].id, m_q[0].resp, m_q[0].last);
            void'(m_q.pop_front());
         end
         if (mr_hs) begin
            if (m_lens.size() == 0) begin
               set_u = 1;
            end else begin
               exp_last = (m_idx == int'(m_lens[0]));
               if (mr_rlast != exp_last) set_r = 1;
               if (exp_last) begin
                  void'(m_lens.pop_front());
                  m_idx = 0;
               end else begin
                  m_idx++;
               end
            end
            nb.data = mr_rdata;
            nb.id   = mr_rid;
            nb.resp = axi_resp_e'(mr_rresp);
            nb.last = mr_rlast;
            m_q.push_back(nb);
         end
         if (ar_ok) m_lens.push_back(dr_arlen);
         m_err_r = err_clr ? 1'b0 : (m_err_r | set_r);
         m_err_u = err_clr ? 1'b0 : (m_err_u | set_u);
      end
   end

   task automatic send_ar(input logic [7:0] len);
      bit done = 0;
      dr_araddr  = $urandom;
      dr_arid    = IW'($urandom);
      dr_arlen   = len;
      dr_arvalid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (dr_arready) done = 1;
      end
      if (done) begin
         @(posedge clk);
         #1;
      end
      dr_arvalid = 1'b0;
      check_eq("ar_handshake", done, 1'b1);
   endtask

   task automatic send_beat(input logic [DW-1:0] data, input logic last);
      bit done = 0;
      mr_rdata  = data;
      mr_rid    = IW'($urandom);
      mr_rresp  = 2'($urandom);
      mr_rlast  = last;
      mr_rvalid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (mr_rready) done = 1;
      end
      if (done) begin
         @(posedge clk);
         #1;
      end
      mr_rvalid = 1'b0;
      check_eq("r_handshake", done, 1'b1);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [7:0] stim_lens[$];
   bit         rand_on = 0;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_dr_rvalid", dr_rvalid, 1'b0);
      check_eq("rst_mr_rready", mr_rready, 1'b1);
      check_eq("rst_errs", {err_rlast, err_unexp}, 2'b00);
      check_eq("rst_dr_payload", {dr_rdata, dr_rid, dr_rresp, dr_rlast}, '0);
      tick(1);

      // Single 4-beat burst, back-to-back beats
      send_ar(8'd3);
      for (int i = 0; i < 4; i++) send_beat(64'hD0 + 64'(i), i == 3);
      tick(3);

      // Driver stall mid-burst
      send_ar(8'd5);
      fork
         for (int i = 0; i < 6; i++) send_beat(64'hA0 + 64'(i), i == 5);
         begin
            tick(2);
            dr_rready = 1'b0;
            tick(3);
            check_eq("stall_mr_rready", mr_rready, 1'b0);
            dr_rready = 1'b1;
         end
      join
      tick(4);

      // ARLEN FIFO full blocks the fifth request until a burst retires
      for (int i = 0; i < 4; i++) send_ar(8'd0);
      fork
         send_ar(8'd0);
         begin
            repeat (3) begin
               @(negedge clk);
               check_eq("ar_blocked", {dr_arready, mr_arvalid}, 2'b00);
            end
            tick(1);
            send_beat(64'hB0, 1'b1);
         end
      join
      for (int i = 1; i < 5; i++) send_beat(64'hB0 + 64'(i), 1'b1);
      tick(3);

      // Early RLAST
      send_ar(8'd1);
      send_beat(64'hC0, 1'b1);
      @(negedge clk);
      check_eq("early_rlast_flag", err_rlast, 1'b1);
      tick(1);
      send_beat(64'hC1, 1'b1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      @(negedge clk);
      check_eq("rlast_cleared", err_rlast, 1'b0);
      tick(1);

      // Unexpected beat, then set and clear in the same cycle
      send_beat(64'hE0, 1'b1);
      @(negedge clk);
      check_eq("unexp_flag", err_unexp, 1'b1);
      tick(1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b1;
      send_beat(64'hE1, 1'b0);
      err_clr = 1'b0;
      @(negedge clk);
      check_eq("unexp_clr_wins", err_unexp, 1'b0);
      tick(3);

      // Reset in the middle of a burst
      send_ar(8'd3);
      send_beat(64'hF0, 1'b0);
      send_beat(64'hF1, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("midrst_dr_rvalid", dr_rvalid, 1'b0);
      check_eq("midrst_mr_rready", mr_rready, 1'b1);
      check_eq("midrst_dr_arready", dr_arready, 1'b1);
      tick(1);
      rst_n = 1'b1;
      send_ar(8'd0);
      send_beat(64'hF8, 1'b1);
      tick(2);
      check_eq("post_rst_errs", {err_rlast, err_unexp}, 2'b00);

      // Randomized traffic with backpressure on every handshake
      rand_on = 1;
      fork
         begin
            fork
               for (int b = 0; b < 40; b++) begin
                  logic [7:0] len;
                  len = 8'($urandom_range(0, 5));
                  send_ar(len);
                  stim_lens.push_back(len);
                  tick($urandom_range(0, 2));
               end
               for (int b = 0; b < 40; b++) begin
                  logic [7:0] len;
                  bit got = 0;
                  for (int w = 0; w < 2000 && !got; w++) begin
                     if (stim_lens.size() > 0) got = 1;
                     else tick(1);
                  end
                  check_eq("rand_ar_seen", got, 1'b1);
                  if (got) begin
                     len = stim_lens.pop_front();
                     for (int k = 0; k <= int'(len); k++) begin
                        bit last;
                        last = (k == int'(len));
                        if ($urandom_range(0, 19) == 0) last = ~last;
                        send_beat({$urandom, $urandom}, last);
                        if ($urandom_range(0, 3) == 0) tick(1);
                     end
                  end
               end
            join
            rand_on = 0;
         end
         while (rand_on || n_vec == 0) begin
            @(posedge clk);
            #1;
            if (!rand_on) break;
            dr_rready  = ($urandom_range(0, 3) != 0);
            mr_arready = ($urandom_range(0, 2) != 0);
            err_clr    = ($urandom_range(0, 15) == 0);
         end
      join
      dr_rready  = 1'b1;
      mr_arready = 1'b1;
      err_clr    = 1'b0;
      tick(6);
      check_eq("drained_dr_rvalid", dr_rvalid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
